alu_arbiter: RTL
================

// Module: alu_arbiter
// PURPOSE
//  Shares one combinational ALU between NUM_REQ requesters (e.g. execute pipe, address-gen unit).
//  Per cycle: picks at most one valid request by round-robin, drives the ALU, registers the result.
//  Each requester gets a one-deep response slot with a valid/ready handshake.
//  Sits between the requesters and the single ALU instance; the ALU itself stays outside.
// PARAMETERS
//  NUM_REQ  2   number of requesters, >=2
//  XLEN     32  operand/result width; must match the ALU
// PORTS
//  clk         in   1              clock; all state on rising edge
//  rst_n       in   1              async active-low reset
//  req_valid   in   NUM_REQ        request i presents an operation
//  req_ready   out  NUM_REQ        request i accepted this cycle
//  req_src_a   in   NUM_REQ*XLEN   operand A per requester
//  req_src_b   in   NUM_REQ*XLEN   operand B per requester
//  req_ctrl    in   NUM_REQ*5      ALU op code per requester
//  rsp_valid   out  NUM_REQ        slot i holds a result
//  rsp_ready   in   NUM_REQ        requester i consumes the slot
//  rsp_result  out  NUM_REQ*XLEN   registered result for i
//  rsp_err     out  NUM_REQ        slot i result came from an illegal op code
//  alu_src_a   out  XLEN           to the ALU
//  alu_src_b   out  XLEN           to the ALU
//  alu_ctrl    out  5              to the ALU
//  alu_result  in   XLEN           from the ALU, combinational
// BEHAVIOUR
//  Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
//  Reset values:
//   - rsp_valid=0, rsp_result=0, rsp_err=0.
//   - RR pointer=NUM_REQ-1, so requester 0 has top priority first.
//  Eligibility: elig[i] = req_valid[i] && (!rsp_valid[i] || rsp_ready[i]).
//   - A full slot that is drained this same cycle may be refilled this cycle (no bubble).
//  Arbitration:
//   - Round-robin over elig, searching from ptr+1 upward with wrap.
//   - At most one grant per cycle; req_ready = one-hot grant.
//   - ptr moves to the granted index only when a grant occurs; otherwise it holds.
//   - req_ready may depend on req_valid; requesters must not make valid depend on ready.
//  ALU drive:
//   - Granted requester's src_a, src_b and ctrl go to the ALU combinationally.
//   - With no grant, or with an illegal op, the ALU is driven with all-zero operands and ctrl=0.
//  Op codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA.
//   - Codes 8..31 are illegal. Such a request is still accepted and completes:
//     rsp_result=0, rsp_err=1. The ALU output is never sampled for it (the ALU gives X).
//  Latency: request accepted at edge N -> rsp_valid/rsp_result valid after edge N (1 cycle).
//  Slot i update, per edge:
//   - grant[i]: load result and err, set valid.
//   - else rsp_valid && rsp_ready: clear valid; result and err hold their last value.
//   - else hold.
//  Backpressure: a full, undrained slot blocks only its own requester; others keep being served.
//  Reset mid-operation: slots clear immediately and accepted-but-unconsumed results are lost;
//   requesters re-issue. The ALU drive returns to zero.
//  Requests stay valid/stable until accepted (requester duty; a bench assertion checks it).
// STRUCTURE
//  Shared package alu_pkg:
//   - XLEN, ALU_CTRL_W=5
//   - alu_op_e enum (ADD..SRA)
//   - function alu_op_legal()
//  Sub-module rr_arbiter #(N): elig -> one-hot grant, owns the pointer; reusable elsewhere.
//  Top level: eligibility, operand mux, per-requester slot registers.
// TESTING
//  1 Single req0 ADD 5+7 -> req_ready[0] same cycle; next cycle rsp_valid[0]=1, result=12, err=0.
//  2 Both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1.
//    req0 SUB 10-3 gives 7; req1 SRA 0x80000000>>4 gives 0xF8000000.
//  3 rsp_ready[1]=0 with slot 1 full -> req1 stalls and req0 is granted every cycle.
//    Raising rsp_ready[1] lets req1 be granted that same cycle.
//  4 req_ctrl=5'd9 -> accepted; rsp_result=0, rsp_err=1; alu_ctrl=0 and operands 0 that cycle.
//  5 SLL 1<<33 (src_b=33) -> result 2; only src_b[4:0] is used, via the ALU.
//  6 rst_n low mid-stream with both slots full -> rsp_valid=0 immediately, without a clock.
//    After release, req0 is granted first.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared ALU widths, op-code enumeration and legality helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int XLEN       = 32;
    localparam int ALU_CTRL_W = 5;

    typedef enum logic [ALU_CTRL_W-1:0] {
        ALU_ADD = 5'd0,
        ALU_SUB = 5'd1,
        ALU_AND = 5'd2,
        ALU_OR  = 5'd3,
        ALU_XOR = 5'd4,
        ALU_SLL = 5'd5,
        ALU_SRL = 5'd6,
        ALU_SRA = 5'd7
    } alu_op_e;

    function automatic logic alu_op_legal(input logic [ALU_CTRL_W-1:0] op);
        return (op <= ALU_SRA);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter_if
//  Description : Requester, response-slot and ALU bundle of the shared-ALU arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int XLEN    = alu_pkg::XLEN
);
    logic [NUM_REQ-1:0]                     req_valid;
    logic [NUM_REQ-1:0]                     req_ready;
    logic [NUM_REQ*XLEN-1:0]                req_src_a;
    logic [NUM_REQ*XLEN-1:0]                req_src_b;
    logic [NUM_REQ*alu_pkg::ALU_CTRL_W-1:0] req_ctrl;
    logic [NUM_REQ-1:0]                     rsp_valid;
    logic [NUM_REQ-1:0]                     rsp_ready;
    logic [NUM_REQ*XLEN-1:0]                rsp_result;
    logic [NUM_REQ-1:0]                     rsp_err;
    logic [XLEN-1:0]                        alu_src_a;
    logic [XLEN-1:0]                        alu_src_b;
    logic [alu_pkg::ALU_CTRL_W-1:0]         alu_ctrl;
    logic [XLEN-1:0]                        alu_result;

    modport slave (
        input  req_valid, req_src_a, req_src_b, req_ctrl, rsp_ready, alu_result,
        output req_ready, rsp_valid, rsp_result, rsp_err, alu_src_a, alu_src_b, alu_ctrl
    );

    modport master (
        output req_valid, req_src_a, req_src_b, req_ctrl, rsp_ready, alu_result,
        input  req_ready, rsp_valid, rsp_result, rsp_err, alu_src_a, alu_src_b, alu_ctrl
    );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Round-robin arbiter, one-hot grant; pointer tracks last grant.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] i_elig,
    output logic [N-1:0] o_grant
);
    localparam int c_PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [c_PTR_W-1:0] r_ptr;
    logic [c_PTR_W-1:0] w_next_ptr;
    int                 w_best;
    int                 w_sel;
    int                 w_dist;

    // Distance from ptr+1 with wrap; the smallest eligible distance wins.
    always_comb begin
        w_best     = N;
        w_sel      = 0;
        w_dist     = 0;
        o_grant    = '0;
        w_next_ptr = r_ptr;
        for (int i = 0; i < N; i++) begin
            w_dist = (i + N - 1 - int'(r_ptr)) % N;
            if (i_elig[i] && (w_dist < w_best)) begin
                w_best = w_dist;
                w_sel  = i;
            end
        end
        for (int i = 0; i < N; i++) begin
            o_grant[i] = (w_best < N) && (w_sel == i);
        end
        if (w_best < N) begin
            w_next_ptr = c_PTR_W'(w_sel);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= c_PTR_W'(N - 1);
        end else if (|o_grant) begin
            r_ptr <= w_next_ptr;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter
//  Description : Shares one combinational ALU among NUM_REQ requesters with
//                round-robin grant and a one-deep response slot per requester.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int XLEN    = alu_pkg::XLEN
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_arbiter_if.slave  bus
);
    import alu_pkg::*;

    logic [NUM_REQ-1:0]                 w_elig;
    logic [NUM_REQ-1:0]                 w_grant;
    logic [NUM_REQ-1:0][XLEN-1:0]       w_src_a;
    logic [NUM_REQ-1:0][XLEN-1:0]       w_src_b;
    logic [NUM_REQ-1:0][ALU_CTRL_W-1:0] w_ctrl;
    logic [XLEN-1:0]                    w_sel_a;
    logic [XLEN-1:0]                    w_sel_b;
    logic [ALU_CTRL_W-1:0]              w_sel_ctrl;
    logic                               w_legal;
    logic                               w_drive;

    logic [NUM_REQ-1:0]                 r_valid;
    logic [NUM_REQ-1:0]                 r_err;
    logic [NUM_REQ-1:0][XLEN-1:0]       r_result;

    assign w_src_a = bus.req_src_a;
    assign w_src_b = bus.req_src_b;
    assign w_ctrl  = bus.req_ctrl;

    // A slot being drained this cycle may be refilled in the same cycle.
    // Gating with rst_n keeps the ALU drive at zero while reset is held.
    assign w_elig = rst_n ? (bus.req_valid & (~r_valid | bus.rsp_ready)) : '0;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_elig  (w_elig),
        .o_grant (w_grant)
    );

    always_comb begin
        w_sel_a    = '0;
        w_sel_b    = '0;
        w_sel_ctrl = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_a    = w_sel_a    | w_src_a[i];
                w_sel_b    = w_sel_b    | w_src_b[i];
                w_sel_ctrl = w_sel_ctrl | w_ctrl[i];
            end
        end
    end

    assign w_legal = alu_op_legal(w_sel_ctrl);
    assign w_drive = (|w_grant) && w_legal;

    assign bus.alu_src_a = w_drive ? w_sel_a    : '0;
    assign bus.alu_src_b = w_drive ? w_sel_b    : '0;
    assign bus.alu_ctrl  = w_drive ? w_sel_ctrl : '0;

    // Illegal ops never sample the ALU output, which may be X for them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= '0;
            r_err    <= '0;
            r_result <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_grant[i]) begin
                    r_valid[i]  <= 1'b1;
                    r_err[i]    <= ~w_legal;
                    r_result[i] <= w_legal ? bus.alu_result : '0;
                end else if (r_valid[i] && bus.rsp_ready[i]) begin
                    r_valid[i]  <= 1'b0;
                end
            end
        end
    end

    assign bus.req_ready  = w_grant;
    assign bus.rsp_valid  = r_valid;
    assign bus.rsp_err    = r_err;
    assign bus.rsp_result = r_result;

endmodule
`default_nettype wire
